// File: rtl/io_sched_pkg.sv
// Shared types and helpers for the UART IO scheduler.
package io_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } state_t;

  // Which kind of IO request went out most recently.
  typedef enum logic {
    LS_READ  = 1'b0,
    LS_WRITE = 1'b1
  } served_t;

  // Requester pointers are sized for the largest supported NREQ and
  // always hold values below the configured NREQ.
  localparam int NREQ_MAX = 4;
  localparam int PTR_W    = $clog2(NREQ_MAX);

  // Advance a round-robin pointer modulo n.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
    return (int'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction

  // First active candidate at or after start (mod n).
  // Result bit PTR_W is the found flag, the low bits the index.
  function automatic logic [PTR_W:0] rr_pick(input logic [NREQ_MAX-1:0] cand,
                                              input logic [PTR_W-1:0]    start,
                                              input int                  n);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      if (k < n && !res[PTR_W]) begin
        idx = (int'(start) + k) % n;
        if (cand[idx[PTR_W-1:0]]) res = {1'b1, idx[PTR_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/io_txfifo.sv
// Byte-wide synchronous FIFO with fall-through head for posted UART writes.
module io_txfifo
  import io_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // The extra pointer bit tells a full FIFO from an empty one.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign dout    = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; overflowing pushes and underflowing pops are dropped.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_sched.sv
// Shares one byte-wide UART IO buffer between NREQ requesters: writes are
// posted into a TX FIFO, reads are arbitrated round-robin, and a small FSM
// alternates FIFO drains and reads towards the IO buffer.
module io_sched
  import io_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TXDEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [NREQ-1:0]          rd_req,
  input  logic [NREQ-1:0]          wr_req,
  input  logic [8*NREQ-1:0]        wr_data,
  output logic [NREQ-1:0]          done,
  output logic [7:0]               rd_data,
  output logic [$clog2(TXDEPTH):0] tx_level,
  output logic                     io_read_req,
  output logic                     io_write_req,
  output logic [7:0]               io_din,
  input  logic                     io_ready,
  input  logic                     io_done,
  input  logic [7:0]               io_dout
);

  state_t             state;
  state_t             state_nxt;
  served_t            last_served;

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_owner;
  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    rd_idx;
  logic [PTR_W:0]      wr_pick;
  logic [PTR_W:0]      rd_pick;
  logic [NREQ_MAX-1:0] wr_cand;
  logic [NREQ_MAX-1:0] rd_cand;
  logic                wr_found;
  logic                rd_found;

  logic                rd_inflight;
  logic                rd_hold;
  logic                rd_ret;
  logic                rd_fin;
  logic                rd_block;
  logic                rd_pending;

  logic [NREQ-1:0]     done_nxt;
  logic                push;
  logic                pop;
  logic [7:0]          push_byte;
  logic [7:0]          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;

  logic                want_wr;
  logic                want_rd;
  logic                issue_wr;
  logic                issue_rd;

  io_txfifo #(
    .DEPTH (TXDEPTH)
  ) u_txfifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (push),
    .din   (push_byte),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (tx_level)
  );

  // Candidate masks: a requester showing done this cycle is not served again,
  // and a requester asking for both is treated as a writer until it drops wr_req.
  always_comb begin
    wr_cand = '0;
    rd_cand = '0;
    wr_cand[NREQ-1:0] = wr_req & ~done;
    rd_cand[NREQ-1:0] = rd_req & ~wr_req & ~done;
  end

  assign wr_pick  = rr_pick(wr_cand, wr_ptr, NREQ);
  assign rd_pick  = rr_pick(rd_cand, rd_ptr, NREQ);
  assign wr_found = wr_pick[PTR_W];
  assign wr_idx   = wr_pick[PTR_W-1:0];
  assign rd_found = rd_pick[PTR_W];
  assign rd_idx   = rd_pick[PTR_W-1:0];
  assign push     = wr_found && !fifo_full;

  // A returned read byte is delivered unless a write post completes for the
  // same requester this cycle; then it is held one cycle so each done is distinct.
  assign rd_ret     = (state == S_RD_WAIT) && io_done;
  assign rd_fin     = rd_ret || rd_hold;
  assign rd_block   = push && (wr_idx == rd_owner);
  assign rd_pending = rd_inflight && !rd_hold;

  // Byte of the selected writer.
  always_comb begin
    push_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(wr_idx) == i) push_byte = wr_data[8*i +: 8];
    end
  end

  // Completion pulses for posted writes and finished reads.
  always_comb begin
    done_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (push && int'(wr_idx) == i)                  done_nxt[i] = 1'b1;
      if (rd_fin && !rd_block && int'(rd_owner) == i) done_nxt[i] = 1'b1;
    end
  end

  // Requester-side registers: write pointer, done pulses and read data.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr  <= '0;
      done    <= '0;
      rd_data <= 8'h00;
    end else begin
      done <= done_nxt;
      if (push)   wr_ptr  <= ptr_inc(wr_idx, NREQ);
      if (rd_ret) rd_data <= io_dout;
    end
  end

  // Read arbitration: latch one owner at a time, advance rd_ptr on completion.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rd_inflight <= 1'b0;
      rd_hold     <= 1'b0;
      rd_owner    <= '0;
      rd_ptr      <= '0;
    end else if (rd_fin) begin
      if (rd_block) begin
        rd_hold <= 1'b1;
      end else begin
        rd_hold     <= 1'b0;
        rd_inflight <= 1'b0;
        rd_ptr      <= ptr_inc(rd_owner, NREQ);
      end
    end else if (!rd_inflight && rd_found) begin
      rd_inflight <= 1'b1;
      rd_owner    <= rd_idx;
    end
  end

  // With both kinds pending, serve the kind not served last time.
  assign want_wr = !fifo_empty && (!rd_pending || last_served == LS_READ);
  assign want_rd = rd_pending && (fifo_empty || last_served == LS_WRITE);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (io_ready) begin
          if (want_wr)      state_nxt = S_WR_WAIT;
          else if (want_rd) state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: if (io_done) state_nxt = S_IDLE;
      S_WR_WAIT: if (io_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: at most one IO request per idle cycle with io_ready.
  always_comb begin
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    if (state == S_IDLE && io_ready) begin
      if (want_wr)      issue_wr = 1'b1;
      else if (want_rd) issue_rd = 1'b1;
    end
  end

  assign pop = issue_wr;

  // Registered IO request strobes, outgoing byte and last-served kind.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      io_read_req  <= 1'b0;
      io_write_req <= 1'b0;
      io_din       <= 8'h00;
      last_served  <= LS_READ;
    end else begin
      io_read_req  <= issue_rd;
      io_write_req <= issue_wr;
      if (issue_wr) begin
        io_din      <= fifo_head;
        last_served <= LS_WRITE;
      end else if (issue_rd) begin
        last_served <= LS_READ;
      end
    end
  end

endmodule

// File: tb/tb_io_sched.sv
// Bench for io_sched: cycle-exact vector table, then IO-model driven sequences.
module tb_io_sched;
  localparam int NREQ    = 2;
  localparam int TXDEPTH = 8;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [1:0]  rd_req;
  logic [1:0]  wr_req;
  logic [15:0] wr_data;
  logic [1:0]  done;
  logic [7:0]  rd_data;
  logic [3:0]  tx_level;
  logic        io_read_req;
  logic        io_write_req;
  logic [7:0]  io_din;
  logic        io_ready;
  logic        io_done;
  logic [7:0]  io_dout;

  // Table-mode drive vs. IO model drive
  logic        use_model;
  logic        t_ready, t_done;
  logic [7:0]  t_dout;
  logic        m_hold, m_busy, m_done;
  logic [1:0]  m_cnt;
  logic [7:0]  m_dout, m_rbyte;
  logic [8:0]  ev_q[$];

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  assign io_ready = use_model ? (!m_hold && !m_busy) : t_ready;
  assign io_done  = use_model ? m_done : t_done;
  assign io_dout  = use_model ? m_dout : t_dout;

  io_sched #(.NREQ(NREQ), .TXDEPTH(TXDEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .done(done), .rd_data(rd_data), .tx_level(tx_level),
    .io_read_req(io_read_req), .io_write_req(io_write_req), .io_din(io_din),
    .io_ready(io_ready), .io_done(io_done), .io_dout(io_dout)
  );

  // IO buffer model: busy for two cycles after each request, logs requests
  always @(posedge CLK) begin
    if (!RSTN || !use_model) begin
      m_busy <= 1'b0;
      m_cnt  <= 2'd0;
      m_done <= 1'b0;
      m_dout <= 8'h00;
    end else begin
      m_done <= 1'b0;
      if (io_write_req || io_read_req) begin
        m_busy <= 1'b1;
        m_cnt  <= 2'd2;
        ev_q.push_back({io_write_req, io_write_req ? io_din : 8'h00});
      end else if (m_busy) begin
        if (m_cnt == 2'd1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dout <= m_rbyte;
        end
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        rstn;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        rdy;
    logic        iod;
    logic [7:0]  dout;
    logic [23:0] exp;   // {done, rd_data, tx_level, io_read_req, io_write_req, io_din}
  } vec_t;

  vec_t tv[$];

  task automatic addv(input logic rstn, input logic [1:0] rd, input logic [1:0] wr,
                      input logic [15:0] wd, input logic rdy, input logic iod,
                      input logic [7:0] dout, input logic [1:0] e_done,
                      input logic [7:0] e_rd, input logic [3:0] e_lvl,
                      input logic e_rr, input logic e_wr, input logic [7:0] e_din);
    vec_t v;
    v.rstn = rstn; v.rd = rd; v.wr = wr; v.wd = wd; v.rdy = rdy; v.iod = iod; v.dout = dout;
    v.exp  = {e_done, e_rd, e_lvl, e_rr, e_wr, e_din};
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int i, input int max, output bit got);
    got = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (done[i]) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_events(input int n, input int max, output bit got);
    got = 1'b0;
    for (int k = 0; k < max; k++) begin
      if (ev_q.size() >= n) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic post(input int i, input logic [7:0] b, output bit got);
    wr_data[8*i +: 8] = b;
    wr_req[i] = 1'b1;
    wait_done(i, 20, got);
    wr_req[i] = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0; rd_req = '0; wr_req = '0; m_hold = 1'b0;
    tick(); tick();
    RSTN = 1'b1;
  endtask

  initial begin
    int  base;
    bit  ok;
    bit  seen;

    RSTN = 1'b0; rd_req = '0; wr_req = '0; wr_data = '0;
    use_model = 1'b0; t_ready = 1'b0; t_done = 1'b0; t_dout = 8'h00;
    m_hold = 1'b0; m_rbyte = 8'h00;

    //   rstn rd    wr    wd        rdy  iod  dout     done  rdata  lvl  rr wr din
    addv(0, 2'b00, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h00, 4'd0, 0, 0, 8'h00); // reset
    addv(1, 2'b00, 2'b01, 16'h0041, 1, 0, 8'h00, 2'b01, 8'h00, 4'd1, 0, 0, 8'h00); // post 0x41
    addv(1, 2'b00, 2'b01, 16'h0041, 1, 0, 8'h00, 2'b00, 8'h00, 4'd0, 0, 1, 8'h41); // masked, pop
    addv(1, 2'b00, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h00, 4'd0, 0, 0, 8'h41); // write wait
    addv(1, 2'b00, 2'b00, 16'h0000, 0, 1, 8'h00, 2'b00, 8'h00, 4'd0, 0, 0, 8'h41); // write done, no pulse
    addv(1, 2'b10, 2'b00, 16'h0000, 1, 0, 8'h00, 2'b00, 8'h00, 4'd0, 0, 0, 8'h41); // read latched
    addv(1, 2'b10, 2'b00, 16'h0000, 1, 0, 8'h00, 2'b00, 8'h00, 4'd0, 1, 0, 8'h41); // read issued
    addv(1, 2'b10, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h00, 4'd0, 0, 0, 8'h41); // read wait
    addv(1, 2'b10, 2'b00, 16'h0000, 0, 1, 8'h5A, 2'b10, 8'h5A, 4'd0, 0, 0, 8'h41); // io_done -> done[1]
    addv(1, 2'b10, 2'b00, 16'h0000, 1, 0, 8'h00, 2'b00, 8'h5A, 4'd0, 0, 0, 8'h41); // masked, no 2nd read
    addv(1, 2'b00, 2'b00, 16'h0000, 1, 1, 8'h77, 2'b00, 8'h5A, 4'd0, 0, 0, 8'h41); // stray io_done ignored
    addv(1, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 2'b00, 8'h5A, 4'd0, 0, 0, 8'h41); // idle
    addv(1, 2'b01, 2'b01, 16'h0066, 0, 0, 8'h00, 2'b01, 8'h5A, 4'd1, 0, 0, 8'h41); // rd+wr: write first
    addv(1, 2'b01, 2'b01, 16'h0066, 0, 0, 8'h00, 2'b00, 8'h5A, 4'd1, 0, 0, 8'h41); // masked
    addv(1, 2'b01, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h5A, 4'd1, 0, 0, 8'h41); // read latched, not ready
    addv(1, 2'b01, 2'b00, 16'h0000, 1, 0, 8'h00, 2'b00, 8'h5A, 4'd0, 0, 1, 8'h66); // FIFO wins first
    addv(1, 2'b01, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h5A, 4'd0, 0, 0, 8'h66); // write wait
    addv(1, 2'b01, 2'b00, 16'h0000, 0, 1, 8'h00, 2'b00, 8'h5A, 4'd0, 0, 0, 8'h66); // write done
    addv(1, 2'b01, 2'b00, 16'h0000, 1, 0, 8'h00, 2'b00, 8'h5A, 4'd0, 1, 0, 8'h66); // read issued
    addv(1, 2'b01, 2'b00, 16'h0000, 0, 1, 8'h3C, 2'b01, 8'h3C, 4'd0, 0, 0, 8'h66); // read returns
    addv(1, 2'b01, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h3C, 4'd0, 0, 0, 8'h66); // masked
    addv(0, 2'b00, 2'b00, 16'h0000, 0, 0, 8'h00, 2'b00, 8'h00, 4'd0, 0, 0, 8'h00); // reset clears

    foreach (tv[i]) begin
      RSTN = tv[i].rstn; rd_req = tv[i].rd; wr_req = tv[i].wr; wr_data = tv[i].wd;
      t_ready = tv[i].rdy; t_done = tv[i].iod; t_dout = tv[i].dout;
      tick();
      check($sformatf("tbl_v%0d", i),
            {8'h00, done, rd_data, tx_level, io_read_req, io_write_req, io_din},
            {8'h00, tv[i].exp});
    end

    // Simultaneous writes, FIFO order and round-robin
    use_model = 1'b1; t_done = 1'b0;
    do_reset();
    base = ev_q.size();
    wr_data = 16'h2010; wr_req = 2'b11;
    tick(); check("t3_first", done, 2'b01);
    tick(); check("t3_second", done, 2'b10);
    wr_req = 2'b10;
    tick(); check("t3_quiet", done, 2'b00);
    wr_req = 2'b00;
    wr_data = 16'h0033; wr_req = 2'b01;
    tick(); check("t3_single", done, 2'b01);
    wr_req = 2'b00;
    tick(); check("t3_gap", done, 2'b00);
    wr_data = 16'h4455; wr_req = 2'b11;
    tick(); check("t3_rr_first", done, 2'b10);
    tick(); check("t3_rr_second", done, 2'b01);
    wr_req = 2'b00;
    wait_events(base + 5, 100, ok);
    check("t3_events", ok, 1);
    check("t3_ev0", ev_q[base],     {1'b1, 8'h10});
    check("t3_ev1", ev_q[base + 1], {1'b1, 8'h20});
    check("t3_ev2", ev_q[base + 2], {1'b1, 8'h33});
    check("t3_ev3", ev_q[base + 3], {1'b1, 8'h44});
    check("t3_ev4", ev_q[base + 4], {1'b1, 8'h55});

    // FIFO full with the IO buffer stalled
    do_reset();
    base = ev_q.size();
    m_hold = 1'b1;
    for (int k = 0; k < 8; k++) begin
      post(0, 8'h80 + 8'(k), ok);
      check($sformatf("t4_post%0d", k), ok, 1);
    end
    check("t4_full_lvl", tx_level, 4'd8);
    wr_data[7:0] = 8'h88; wr_req[0] = 1'b1;
    wait_done(0, 6, ok);
    check("t4_withheld", ok, 0);
    check("t4_lvl_sat", tx_level, 4'd8);
    m_hold = 1'b0;
    wait_done(0, 20, ok);
    check("t4_ninth", ok, 1);
    wr_req[0] = 1'b0;
    wait_events(base + 9, 200, ok);
    check("t4_events", ok, 1);
    for (int k = 0; k < 9; k++)
      check($sformatf("t4_ev%0d", k), ev_q[base + k], {1'b1, 8'h80 + 8'(k)});

    // Alternation between FIFO drain and a pending read
    do_reset();
    base = ev_q.size();
    m_hold = 1'b1;
    post(1, 8'hA1, ok); post(1, 8'hA2, ok); post(1, 8'hA3, ok);
    check("t5_lvl", tx_level, 4'd3);
    m_rbyte = 8'hC3; rd_req[0] = 1'b1;
    tick(); tick();
    m_hold = 1'b0;
    wait_done(0, 100, ok);
    check("t5_rd_done", ok, 1);
    check("t5_rd_data", rd_data, 8'hC3);
    rd_req[0] = 1'b0;
    wait_events(base + 4, 100, ok);
    check("t5_events", ok, 1);
    check("t5_ev0", ev_q[base],     {1'b1, 8'hA1});
    check("t5_ev1", ev_q[base + 1], {1'b0, 8'h00});
    check("t5_ev2", ev_q[base + 2], {1'b1, 8'hA2});
    check("t5_ev3", ev_q[base + 3], {1'b1, 8'hA3});
    tick(); tick(); tick(); tick();

    // Reset while a read is in flight
    m_rbyte = 8'hE7; rd_req[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (io_read_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_rd_issued", ok, 1);
    RSTN = 1'b0; rd_req = '0;
    tick();
    check("t6_rst_vals", {done, rd_data, tx_level, io_read_req, io_write_req, io_din}, 24'h0);
    RSTN = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (|done || io_read_req || io_write_req) seen = 1'b1;
    end
    check("t6_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
